// File: rtl/dma_pcie_c2h_axis_fifo.sv
// C2H AXI-Stream buffer with a registered first-word-fall-through head, cut-through or packet mode.
// Optional per-byte parity storage/checking is enabled by defining DMA_C2H_AXIS_PARITY_CHK_EN.
module dma_pcie_c2h_axis_fifo #(
  parameter int DATA_W   = 512,
  parameter int USER_W   = 64,
  parameter int DEPTH    = 64,
  parameter int PKT_MODE = 0,
  localparam int KEEP_W  = DATA_W / 8,
  localparam int PW      = $clog2(DEPTH) + 1
) (
  input  logic              user_clk,
  input  logic              user_reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tparity,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_tlast,
  input  logic [USER_W-1:0] s_tusr,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tparity,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tlast,
  output logic [USER_W-1:0] m_tusr,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [PW-1:0]     fill_level,
  output logic [PW-1:0]     pkt_count,
  output logic              par_err,
  input  logic              par_err_clr
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = DATA_W + KEEP_W + USER_W + 1;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] s_ent;
  logic [ENT_W-1:0] head_src;
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_inc;
  logic [PW-1:0]    fill_q, pkt_q, fill_nxt, pkt_nxt;
  logic             rdy_q;
  logic             push, pop, head_ld;

  assign push   = s_tvalid & rdy_q;
  assign pop    = m_tvalid & m_tready;
  assign rd_inc = rd_ptr + 1'b1;
  assign s_ent  = {s_tlast, s_tusr, s_tkeep, s_tdata};

  always_comb begin
    fill_nxt = fill_q;
    pkt_nxt  = pkt_q;
    if (push && !pop)
      fill_nxt = fill_q + 1'b1;
    else if (pop && !push)
      fill_nxt = fill_q - 1'b1;
    if ((push && s_tlast) && !(pop && m_tlast))
      pkt_nxt = pkt_q + 1'b1;
    else if ((pop && m_tlast) && !(push && s_tlast))
      pkt_nxt = pkt_q - 1'b1;
  end

  // The head refills when it is empty or being popped; with at most one beat stored the next head is the incoming beat.
  always_comb begin
    head_ld  = (push && fill_q == '0) || (pop && (fill_q > PW'(1) || push));
    head_src = (fill_q <= PW'(1)) ? s_ent : mem[rd_inc[AW-1:0]];
  end

  always_ff @(posedge user_clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= s_ent;
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
      pkt_q  <= '0;
      rdy_q  <= 1'b0;
      head   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_inc;
      fill_q <= fill_nxt;
      pkt_q  <= pkt_nxt;
      rdy_q  <= (fill_nxt != PW'(DEPTH));
      if (head_ld)
        head <= head_src;
    end
  end

  generate
    if (PKT_MODE != 0) begin : g_sf
      // Forcing valid when full lets packets longer than the buffer drain instead of deadlocking.
      assign m_tvalid = (pkt_q != '0) | (fill_q == PW'(DEPTH));
    end else begin : g_ct
      assign m_tvalid = (fill_q != '0);
    end
  endgenerate

  assign {m_tlast, m_tusr, m_tkeep, m_tdata} = head;
  assign s_tready   = rdy_q;
  assign fill_level = fill_q;
  assign pkt_count  = pkt_q;

`ifdef DMA_C2H_AXIS_PARITY_CHK_EN
  logic [KEEP_W-1:0] par_mem [DEPTH];
  logic [KEEP_W-1:0] head_par;
  logic [KEEP_W-1:0] calc_par;

  always_comb begin
    calc_par = '0;
    for (int i = 0; i < KEEP_W; i++)
      calc_par[i] = ^s_tdata[8*i +: 8];
  end

  always_ff @(posedge user_clk) begin
    if (push)
      par_mem[wr_ptr[AW-1:0]] <= s_tparity;
  end

  // A parity error on the same cycle as a clear must still be recorded.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      head_par <= '0;
      par_err  <= 1'b0;
    end else begin
      if (head_ld)
        head_par <= (fill_q <= PW'(1)) ? s_tparity : par_mem[rd_inc[AW-1:0]];
      if (push && (calc_par != s_tparity))
        par_err <= 1'b1;
      else if (par_err_clr)
        par_err <= 1'b0;
    end
  end

  assign m_tparity = head_par;
`else
  logic unused_par_inputs;

  assign unused_par_inputs = ^{s_tparity, par_err_clr};
  assign par_err = 1'b0;

  always_comb begin
    m_tparity = '0;
    for (int i = 0; i < KEEP_W; i++)
      m_tparity[i] = ^m_tdata[8*i +: 8];
  end
`endif

endmodule
